arith_carry_resolver: RTL and testbench

//  Downstream of arithmetic_encoder. Receives 9-bit pre-carry words {carry, byte} from renormalisation.

---
 rtl/arith_bitstream_pkg.sv | 20 ++
 rtl/arith_carry_resolver.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_arith_carry_resolver.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arith_bitstream_pkg.sv
// Shared types for the arithmetic bitstream back end: the resolver FSM
// encoding, the 9-bit pre-carry word layout and the two fill byte values.
package arith_bitstream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT  = 2'd1,
        FLUSH = 2'd2
    } fsm_state_t;

    // Pre-carry word from renormalisation: carry into already-produced bytes, plus a new byte.
    typedef struct packed {
        logic       carry;
        logic [7:0] b;
    } precarry_word_t;

    localparam logic [7:0] BYTE_FF = 8'hFF;
    localparam logic [7:0] BYTE_00 = 8'h00;

endpackage

// File: rtl/arith_carry_resolver.sv
// arith_carry_resolver: resolves carry propagation on the arithmetic coder
// output. One byte is held in a cache and runs of 0xFF are only counted, so
// a late carry can still ripple into them. Bytes leave over a registered
// valid/ready stream; a flush drains the cache and any pending 0xFF run.
// Optional statistics ports are built when CARRY_RESOLVER_STATS_EN is defined.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. Once out_valid is raised, out_byte/out_last hold stable until
// that transfer; in_ready does not depend on in_valid.
module arith_carry_resolver
    import arith_bitstream_pkg::*;
#(
    parameter int RUN_WIDTH  = 16,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  general_clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BYTE_WIDTH:0]   in_word,
    input  logic                  in_flush,
    input  logic                  in_word_vld,
    output logic                  out_valid,
    output logic [BYTE_WIDTH-1:0] out_byte,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  flush_done,
    output logic                  err_carry,
    output logic                  err_run,
`ifdef CARRY_RESOLVER_STATS_EN
    output logic [31:0]           byte_count,
    output logic [31:0]           carry_count,
`endif
    output fsm_state_t            dbg_state
);

    localparam logic [BYTE_WIDTH-1:0] FILL_ONES = {BYTE_WIDTH{1'b1}};
    localparam logic [BYTE_WIDTH-1:0] FILL_ZERO = {BYTE_WIDTH{1'b0}};
    localparam logic [RUN_WIDTH-1:0]  RUN_ONE   = {{(RUN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [RUN_WIDTH-1:0]  RUN_MAX   = {RUN_WIDTH{1'b1}};

    fsm_state_t            state_q, state_d;
    logic [BYTE_WIDTH-1:0] cache_q, cache_d;
    logic                  cache_vld_q, cache_vld_d;
    logic [RUN_WIDTH-1:0]  run_q, run_d;
    logic [BYTE_WIDTH-1:0] fill_q, fill_d;
    logic                  flush_pend_q, flush_pend_d;
    logic [RUN_WIDTH-1:0]  rem_q, rem_d;
    logic                  out_valid_q, out_valid_d;
    logic [BYTE_WIDTH-1:0] out_byte_q, out_byte_d;
    logic                  out_last_q, out_last_d;
    logic                  flush_done_q, flush_done_d;
    logic                  err_carry_q, err_carry_d;
    logic                  err_run_q, err_run_d;
    logic                  alive_q, alive_d;

    logic                  accept;
    logic                  out_hs;
    logic                  word_take;
    logic                  w_c;
    logic [BYTE_WIDTH-1:0] w_b;
    logic                  w_is_run;
    logic                  word_has_bytes;
    logic                  p_cache_vld;
    logic [BYTE_WIDTH-1:0] p_cache;
    logic [RUN_WIDTH-1:0]  p_run;
    logic                  fs_cache_vld;
    logic [BYTE_WIDTH-1:0] fs_cache;
    logic [RUN_WIDTH-1:0]  fs_run;
    logic                  fl_any;
    logic [BYTE_WIDTH-1:0] fl_byte;
    logic [RUN_WIDTH-1:0]  fl_rem;
    logic                  fl_last;

    assign accept    = in_valid & in_ready;
    assign out_hs    = out_valid_q & out_ready;
    assign word_take = accept & in_word_vld;
    assign w_c       = in_word[BYTE_WIDTH];
    assign w_b       = in_word[BYTE_WIDTH-1:0];
    assign w_is_run  = (w_b == FILL_ONES) & ~w_c;
    // A resolving word emits the old cache byte and/or the counted run.
    assign word_has_bytes = word_take & ~w_is_run & (cache_vld_q | (run_q != '0));

    // Cache/run as they stand once the accepted word (if any) has been absorbed;
    // a flush in the same request drains from these values.
    always_comb begin
        p_cache_vld = cache_vld_q;
        p_cache     = cache_q;
        p_run       = run_q;
        if (word_take) begin
            if (w_is_run) begin
                p_run = (run_q == RUN_MAX) ? run_q : run_q + RUN_ONE;
            end else begin
                p_cache_vld = 1'b1;
                p_cache     = w_b;
                p_run       = '0;
            end
        end
    end

    // First byte of a flush: cache byte if held, otherwise the first 0xFF of the run.
    always_comb begin
        if (state_q == IDLE) begin
            fs_cache_vld = p_cache_vld;
            fs_cache     = p_cache;
            fs_run       = p_run;
        end else begin
            fs_cache_vld = cache_vld_q;
            fs_cache     = cache_q;
            fs_run       = run_q;
        end
        fl_any = fs_cache_vld | (fs_run != '0);
        if (fs_cache_vld) begin
            fl_byte = fs_cache;
            fl_rem  = fs_run;
            fl_last = (fs_run == '0);
        end else begin
            fl_byte = FILL_ONES;
            fl_rem  = fs_run - RUN_ONE;
            fl_last = (fs_run == RUN_ONE);
        end
    end

    // FSM state register.
    always_ff @(posedge general_clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: EMIT drains a resolved run, FLUSH drains the frame tail.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (word_has_bytes) begin
                        state_d = EMIT;
                    end else if (in_flush && fl_any) begin
                        state_d = FLUSH;
                    end
                end
            end
            EMIT: begin
                if (out_hs && (rem_q == '0)) begin
                    state_d = flush_pend_q ? FLUSH : IDLE;
                end
            end
            FLUSH: begin
                if (out_hs && out_last_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state: cache/run bookkeeping and the registered output byte.
    always_comb begin
        cache_d      = cache_q;
        cache_vld_d  = cache_vld_q;
        run_d        = run_q;
        fill_d       = fill_q;
        flush_pend_d = flush_pend_q;
        rem_d        = rem_q;
        out_valid_d  = out_valid_q;
        out_byte_d   = out_byte_q;
        out_last_d   = out_last_q;
        flush_done_d = 1'b0;
        err_carry_d  = err_carry_q;
        err_run_d    = err_run_q;
        alive_d      = 1'b1;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    cache_d     = p_cache;
                    cache_vld_d = p_cache_vld;
                    run_d       = p_run;
                    if (word_take && w_is_run && (run_q == RUN_MAX)) begin
                        err_run_d = 1'b1;
                    end
                    // Carry with nothing to land in, or landing in 0xFF (wraps to 0x00).
                    if (word_take && w_c && (!cache_vld_q || (cache_q == FILL_ONES))) begin
                        err_carry_d = 1'b1;
                    end
                    if (word_has_bytes) begin
                        fill_d       = w_c ? FILL_ZERO : FILL_ONES;
                        flush_pend_d = in_flush;
                        out_valid_d  = 1'b1;
                        out_last_d   = 1'b0;
                        if (cache_vld_q) begin
                            out_byte_d = cache_q + {{(BYTE_WIDTH-1){1'b0}}, w_c};
                            rem_d      = run_q;
                        end else begin
                            out_byte_d = w_c ? FILL_ZERO : FILL_ONES;
                            rem_d      = run_q - RUN_ONE;
                        end
                    end else if (in_flush) begin
                        if (fl_any) begin
                            out_valid_d = 1'b1;
                            out_byte_d  = fl_byte;
                            out_last_d  = fl_last;
                            rem_d       = fl_rem;
                        end else begin
                            flush_done_d = 1'b1;
                            cache_vld_d  = 1'b0;
                            run_d        = '0;
                        end
                    end
                end
            end
            EMIT: begin
                if (out_hs) begin
                    if (rem_q != '0) begin
                        out_byte_d = fill_q;
                        rem_d      = rem_q - RUN_ONE;
                    end else if (flush_pend_q) begin
                        flush_pend_d = 1'b0;
                        out_byte_d   = fl_byte;
                        out_last_d   = fl_last;
                        rem_d        = fl_rem;
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end
            end
            FLUSH: begin
                if (out_hs) begin
                    if (out_last_q) begin
                        out_valid_d  = 1'b0;
                        out_last_d   = 1'b0;
                        flush_done_d = 1'b1;
                        cache_vld_d  = 1'b0;
                        run_d        = '0;
                    end else begin
                        out_byte_d = FILL_ONES;
                        rem_d      = rem_q - RUN_ONE;
                        out_last_d = (rem_q == RUN_ONE);
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; async reset drops any byte still pending.
    always_ff @(posedge general_clk or negedge reset) begin
        if (!reset) begin
            cache_q      <= '0;
            cache_vld_q  <= 1'b0;
            run_q        <= '0;
            fill_q       <= '0;
            flush_pend_q <= 1'b0;
            rem_q        <= '0;
            out_valid_q  <= 1'b0;
            out_byte_q   <= '0;
            out_last_q   <= 1'b0;
            flush_done_q <= 1'b0;
            err_carry_q  <= 1'b0;
            err_run_q    <= 1'b0;
            alive_q      <= 1'b0;
        end else begin
            cache_q      <= cache_d;
            cache_vld_q  <= cache_vld_d;
            run_q        <= run_d;
            fill_q       <= fill_d;
            flush_pend_q <= flush_pend_d;
            rem_q        <= rem_d;
            out_valid_q  <= out_valid_d;
            out_byte_q   <= out_byte_d;
            out_last_q   <= out_last_d;
            flush_done_q <= flush_done_d;
            err_carry_q  <= err_carry_d;
            err_run_q    <= err_run_d;
            alive_q      <= alive_d;
        end
    end

    // FSM outputs: requests only in IDLE, and never while reset holds outputs low.
    always_comb begin
        in_ready   = alive_q & (state_q == IDLE);
        out_valid  = out_valid_q;
        out_byte   = out_byte_q;
        out_last   = out_last_q;
        flush_done = flush_done_q;
        err_carry  = err_carry_q;
        err_run    = err_run_q;
        dbg_state  = state_q;
    end

`ifdef CARRY_RESOLVER_STATS_EN
    logic [31:0] byte_count_q, byte_count_d;
    logic [31:0] carry_count_q, carry_count_d;

    // Frame statistics; a word accepted during the flush_done cycle still counts.
    always_comb begin
        byte_count_d  = (flush_done_q ? 32'd0 : byte_count_q) + {31'd0, out_hs};
        carry_count_d = (flush_done_q ? 32'd0 : carry_count_q) + {31'd0, word_take & w_c};
    end

    // Statistics registers.
    always_ff @(posedge general_clk or negedge reset) begin
        if (!reset) begin
            byte_count_q  <= '0;
            carry_count_q <= '0;
        end else begin
            byte_count_q  <= byte_count_d;
            carry_count_q <= carry_count_d;
        end
    end

    assign byte_count  = byte_count_q;
    assign carry_count = carry_count_q;
`endif

endmodule

// File: tb/tb_arith_carry_resolver.sv
// Directed bench for arith_carry_resolver. The run counter is built narrow
// so that saturation is reachable in a few cycles.
module tb_arith_carry_resolver;
  import arith_bitstream_pkg::*;

  localparam int RUN_W = 4;

  logic       general_clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_word;
  logic       in_flush;
  logic       in_word_vld;
  logic       out_valid;
  logic [7:0] out_byte;
  logic       out_ready;
  logic       out_last;
  logic       flush_done;
  logic       err_carry;
  logic       err_run;
  fsm_state_t dbg_state;
`ifdef CARRY_RESOLVER_STATS_EN
  logic [31:0] byte_count;
  logic [31:0] carry_count;
`endif

  logic [8:0] exp_q[$];
  int n_vec;
  int n_bad;
  int done_cnt;
  bit rdy_s;

  arith_carry_resolver #(.RUN_WIDTH(RUN_W), .BYTE_WIDTH(8)) dut (
    .general_clk (general_clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_word     (in_word),
    .in_flush    (in_flush),
    .in_word_vld (in_word_vld),
    .out_valid   (out_valid),
    .out_byte    (out_byte),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .flush_done  (flush_done),
    .err_carry   (err_carry),
    .err_run     (err_run),
`ifdef CARRY_RESOLVER_STATS_EN
    .byte_count  (byte_count),
    .carry_count (carry_count),
`endif
    .dbg_state   (dbg_state)
  );

  // clock / watchdog
  initial begin
    general_clk = 1'b0;
    forever #5 general_clk = ~general_clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=summary");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [8:0] mkw(input logic c, input logic [7:0] b);
    precarry_word_t pw;
    pw.carry = c;
    pw.b     = b;
    return pw;
  endfunction

  task automatic push(input logic last, input logic [7:0] b);
    exp_q.push_back({last, b});
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard at the falling edge, return just after the rising edge.
  task automatic tick();
    logic [8:0] e;
    @(negedge general_clk);
    rdy_s = (in_ready === 1'b1);
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_bad++;
        $error("FAIL stray_byte observed=%h expected=none", {out_last, out_byte});
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_vec++;
        assert ({out_last, out_byte} === e) else begin
          n_bad++;
          $error("FAIL out_byte observed=%h expected=%h", {out_last, out_byte}, e);
        end
      end
    end
    if (flush_done === 1'b1) begin
      done_cnt++;
      n_vec++;
      assert (exp_q.size() == 0) else begin
        n_bad++;
        $error("FAIL done_early observed=%0d expected=0", exp_q.size());
      end
    end
    @(posedge general_clk);
    #1;
  endtask

  task automatic send(input logic wv, input logic [8:0] w, input logic fl);
    bit got;
    in_valid    = 1'b1;
    in_word_vld = wv;
    in_word     = w;
    in_flush    = fl;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      tick();
      got = rdy_s;
    end
    in_valid    = 1'b0;
    in_word_vld = 1'b0;
    in_word     = '0;
    in_flush    = 1'b0;
    n_vec++;
    assert (got) else begin
      n_bad++;
      $error("FAIL accept_timeout observed=0 expected=1");
    end
  endtask

  task automatic wait_done(input string tag);
    int start;
    start = done_cnt;
    for (int k = 0; k < 200 && done_cnt == start; k++) tick();
    chk(tag, done_cnt - start, 1);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 200 && (exp_q.size() != 0 || out_valid === 1'b1); k++) tick();
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    in_valid    = 1'b0;
    in_word_vld = 1'b0;
    in_word     = '0;
    in_flush    = 1'b0;
    tick();
    tick();
    exp_q.delete();
    reset = 1'b1;
    tick();
  endtask

  // directed sequence
  initial begin
    n_vec = 0;
    n_bad = 0;
    done_cnt = 0;
    reset = 1'b0;
    in_valid = 1'b0;
    in_word_vld = 1'b0;
    in_word = '0;
    in_flush = 1'b0;
    out_ready = 1'b1;

    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_byte", out_byte, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_err_carry", err_carry, 0);
    chk("rst_err_run", err_run, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_state", dbg_state, IDLE);
    reset = 1'b1;
    tick();
    chk("ready_after_reset", in_ready, 1);

    // case 1: plain bytes, separate flush
    send(1'b1, mkw(1'b0, 8'h12), 1'b0);
    chk("c1_first_word_silent", out_valid, 0);
    push(1'b0, 8'h12);
    send(1'b1, mkw(1'b0, 8'h34), 1'b0);
    chk("c1_valid_next_cycle", {out_valid, out_byte}, {1'b1, 8'h12});
    push(1'b1, 8'h34);
    send(1'b0, '0, 1'b1);
    wait_done("c1_flush_done");
    drain("c1_drain");

    // empty flush: done the cycle after accept, no bytes
    send(1'b0, '0, 1'b1);
    chk("empty_flush_done", flush_done, 1);
    chk("empty_flush_no_byte", out_valid, 0);
    tick();
    chk("empty_flush_pulse_1cyc", flush_done, 0);

    // case 2: carry ripples into a 0xFF run
    send(1'b1, mkw(1'b0, 8'hA0), 1'b0);
    send(1'b1, mkw(1'b0, BYTE_FF), 1'b0);
    send(1'b1, mkw(1'b0, BYTE_FF), 1'b0);
    push(1'b0, 8'hA1);
    push(1'b0, BYTE_00);
    push(1'b0, BYTE_00);
    send(1'b1, mkw(1'b1, 8'h05), 1'b0);
    chk("c2_busy_not_ready", in_ready, 0);
    push(1'b1, 8'h05);
    send(1'b0, '0, 1'b1);
    wait_done("c2_flush_done");
    drain("c2_drain");
    chk("c2_no_err", {err_carry, err_run}, 0);

    // case 3: no carry, run released as 0xFF; word and flush in one request
    send(1'b1, mkw(1'b0, 8'hA0), 1'b0);
    send(1'b1, mkw(1'b0, BYTE_FF), 1'b0);
    send(1'b1, mkw(1'b0, BYTE_FF), 1'b0);
    push(1'b0, 8'hA0);
    push(1'b0, BYTE_FF);
    push(1'b0, BYTE_FF);
    push(1'b1, 8'h10);
    send(1'b1, mkw(1'b0, 8'h10), 1'b1);
    wait_done("c3_flush_done");
    drain("c3_drain");

    // case 4: backpressure holds the first byte
    send(1'b1, mkw(1'b0, 8'hA0), 1'b0);
    send(1'b1, mkw(1'b0, BYTE_FF), 1'b0);
    send(1'b1, mkw(1'b0, BYTE_FF), 1'b0);
    out_ready = 1'b0;
    push(1'b0, 8'hA1);
    push(1'b0, BYTE_00);
    push(1'b0, BYTE_00);
    send(1'b1, mkw(1'b1, 8'h05), 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("c4_hold_byte", {out_valid, out_byte}, {1'b1, 8'hA1});
      chk("c4_hold_not_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    push(1'b1, 8'h05);
    send(1'b0, '0, 1'b1);
    wait_done("c4_flush_done");
    drain("c4_drain");

    // case 5: carry error cases
    do_reset();
    send(1'b1, mkw(1'b1, 8'h55), 1'b0);
    chk("c5_err_no_cache", err_carry, 1);
    chk("c5_no_out", out_valid, 0);
    push(1'b0, 8'h55);
    send(1'b1, mkw(1'b0, 8'h20), 1'b0);
    push(1'b0, 8'h21);
    send(1'b1, mkw(1'b1, BYTE_FF), 1'b0);
    push(1'b0, BYTE_00);
    send(1'b1, mkw(1'b1, 8'h05), 1'b0);
    push(1'b1, 8'h05);
    send(1'b0, '0, 1'b1);
    wait_done("c5_flush_done");
    drain("c5_drain");
    chk("c5_err_sticky", err_carry, 1);

    do_reset();
    chk("c5b_err_cleared", err_carry, 0);
    send(1'b1, mkw(1'b0, 8'h20), 1'b0);
    push(1'b0, 8'h21);
    send(1'b1, mkw(1'b1, BYTE_FF), 1'b0);
    drain("c5b_drain_21");
    chk("c5b_valid_carry_no_err", err_carry, 0);
    push(1'b0, BYTE_00);
    send(1'b1, mkw(1'b1, 8'h05), 1'b0);
    drain("c5b_drain_00");
    chk("c5b_err_cache_ff", err_carry, 1);
    push(1'b1, 8'h05);
    send(1'b0, '0, 1'b1);
    wait_done("c5b_flush_done");
    drain("c5b_drain");

    // run counter saturation (max run 15) then flush of an all-0xFF tail
    do_reset();
    for (int i = 0; i < 15; i++) send(1'b1, mkw(1'b0, BYTE_FF), 1'b0);
    chk("sat_no_err_at_max", err_run, 0);
    chk("sat_no_output", out_valid, 0);
    send(1'b1, mkw(1'b0, BYTE_FF), 1'b0);
    chk("sat_err_run", err_run, 1);
    for (int i = 0; i < 15; i++) push(i == 14, BYTE_FF);
    send(1'b0, '0, 1'b1);
    wait_done("sat_flush_done");
    drain("sat_drain");
    chk("sat_err_sticky", err_run, 1);

    // case 6: async reset in the middle of EMIT drops the pending bytes
    out_ready = 1'b0;
    send(1'b1, mkw(1'b0, 8'hA0), 1'b0);
    send(1'b1, mkw(1'b0, BYTE_FF), 1'b0);
    send(1'b1, mkw(1'b0, BYTE_FF), 1'b0);
    send(1'b1, mkw(1'b1, 8'h05), 1'b0);
    tick();
    chk("c6_stalled", {out_valid, out_byte}, {1'b1, 8'hA1});
    #2;
    reset = 1'b0;
    #1;
    chk("c6_async_valid", out_valid, 0);
    chk("c6_async_byte", out_byte, 0);
    chk("c6_async_ready", in_ready, 0);
    chk("c6_async_err", {err_carry, err_run}, 0);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    push(1'b1, 8'h12);
    send(1'b1, mkw(1'b0, 8'h12), 1'b0);
    send(1'b0, '0, 1'b1);
    wait_done("c6_flush_done");
    drain("c6_drain");

    for (int i = 0; i < 5; i++) tick();
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_idle", dbg_state, IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
